axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
- Shares one AXI-stream slave, for example the memory-fed receiver, among NUM_SRC stream masters.
- Arbitrates round-robin at packet granularity. A granted source owns the output until its tlast beat completes.
- Sits between several data-generating masters and a single consumer. Tags each beat with its source id and keeps a running completed-packet count.

Parameters:
- NUM_SRC, 4, number of requesting stream masters (2..8).
- DATA_W, 8, tdata width per source.
- ID_W, 2, width of source id; must satisfy 2**ID_W >= NUM_SRC.
- CNT_W, 16, width of completed-packet counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- resetn  input  1  synchronous, active-low reset.
- s_tvalid  input  NUM_SRC  per-source valid; bit i belongs to source i.
- s_tdata  input  NUM_SRC*DATA_W  per-source data; source i at bits [i*DATA_W +: DATA_W].
- s_tlast  input  NUM_SRC  per-source end-of-packet.
- s_tready  output  NUM_SRC  per-source ready.
- src_enable  input  NUM_SRC  mask of sources eligible for new grants.
- m_tvalid  output  1  output valid.
- m_tdata  output  DATA_W  output data.
- m_tlast  output  1  output end-of-packet.
- m_tid  output  ID_W  source id of the current beat.
- m_tready  input  1  downstream ready.
- busy  output  1  high while a packet grant is held.
- pkt_count  output  CNT_W  number of packets fully forwarded.

Behaviour:
- Reset: synchronous; sampled on posedge clk when resetn=0.
  - State goes to IDLE; busy=0, grant=0, pkt_count=0.
  - last_grant=NUM_SRC-1, so source 0 has first priority.
  - All outputs driven from state: s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tid=0.
  - Reset mid-packet abandons the packet; no partial-packet recovery.
- States: IDLE, BUSY.
- IDLE:
  - req = s_tvalid & src_enable.
  - If req != 0, select the first set bit searching from (last_grant+1) mod NUM_SRC upward with wrap.
  - Register the selection as grant, set busy=1, go to BUSY on the next edge.
  - One-cycle arbitration bubble; no beat is transferred in IDLE.
  - If req == 0, remain in IDLE.
- BUSY:
  - Combinational pass-through of the granted source, zero latency:
    - m_tvalid = s_tvalid[grant]
    - m_tdata = s_tdata[grant]
    - m_tlast = s_tlast[grant]
    - m_tid = grant
    - s_tready[grant] = m_tready; all other s_tready bits = 0
  - Beat transfer = m_tvalid & m_tready.
  - On a transfer with m_tlast=1:
    - last_grant <= grant, busy <= 0, pkt_count <= pkt_count+1, go to IDLE.
  - Otherwise remain in BUSY, including while the granted source deasserts tvalid mid-packet (gaps allowed, grant held).
- In IDLE: s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0; m_tid holds the last grant.
- src_enable:
  - Only consulted in IDLE.
  - Deasserting the granted bit mid-packet does not abort; takes effect at the next arbitration.
- Back-to-back packets: minimum one IDLE cycle between packets, even from the same source. Max throughput for a single-beat packet is 1 per 2 cycles.
- Fairness: a source that just finished has lowest priority next round. With all sources requesting, grant order is 0,1,2,3,0,...
- pkt_count wraps from 2**CNT_W-1 to 0 with no saturation.
- Stall hold: m_tdata and m_tlast follow the source. The source must hold them while tvalid is high and tready is low, per AXI-stream rules; the arbiter adds no buffering.
- Grant ids >= NUM_SRC are unreachable.

Test Plan:
- Reset release, all s_tvalid=0, src_enable=4'hF, m_tready=1 -> state IDLE, m_tvalid=0, busy=0, pkt_count=0 for 10 cycles.
- Source 2 alone sends a 3-beat packet 8'h10,8'h11,8'h12, m_tready=1:
  - busy rises 1 cycle after s_tvalid[2].
  - Output is 3 beats with m_tid=2; tlast on 8'h12.
  - pkt_count=1; busy=0 the cycle after.
- All 4 sources continuously offer 2-beat packets, m_tready=1 -> grant order 0,1,2,3,0; each packet 2 beats followed by 1 idle cycle; pkt_count=5 after 15 cycles.
- Source 1 granted, m_tready toggled 1,0,1,0 during a 4-beat packet (8'h1D,8'h1E,8'h1F,8'h20), source 0 also requesting:
  - Data unchanged during stalls; no interleaving of source 0.
  - Source 0 granted only after tlast of source 1.
- src_enable=4'b1010 with all sources valid -> only sources 1 and 3 ever granted, alternating.
  - Clearing bit 3 mid-packet on source 3 -> that packet completes, then only source 1 is granted.
- resetn=0 asserted mid-packet on beat 2 of 4 -> next cycle m_tvalid=0, s_tready=0, pkt_count=0.
  - After release, source 0 is granted first if requesting.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
//   Shares one AXI-stream slave among NUM_SRC stream masters. Arbitration is
//   round-robin at packet granularity: once a source is granted it owns the
//   output until its tlast beat is accepted. Every beat carries the id of the
//   source it came from, and a free-running counter tracks forwarded packets.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   s_tvalid/s_tdata/    per-source slave streams; source i is bit i and
//   s_tlast/s_tready     data slice [i*DATA_W +: DATA_W]
//   src_enable           per-source eligibility mask for new grants
//   m_tvalid/m_tdata/    merged master stream; m_tid names the source of
//   m_tlast/m_tid/       the beat currently presented
//   m_tready
//   busy                 high while a packet grant is held
//   pkt_count            packets fully forwarded (wraps)

// One source lane: decides whether this source is the granted one and, if so,
// exposes its beat and passes downstream ready back to it. Non-granted lanes
// contribute zeros so the top level can merge lanes with a plain OR.
module axis_arb_lane #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 2,
    parameter int IDX    = 0
) (
    input  logic              busy,
    input  logic [ID_W-1:0]   grant,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              m_tready,
    output logic              s_tready,
    output logic              sel_valid,
    output logic [DATA_W-1:0] sel_data,
    output logic              sel_last
);
    localparam logic [ID_W-1:0] LANE_ID = ID_W'(IDX);

    logic sel;
    assign sel       = busy && (grant == LANE_ID);
    assign s_tready  = sel && m_tready;
    assign sel_valid = sel && s_tvalid;
    assign sel_data  = sel ? s_tdata : '0;
    assign sel_last  = sel && s_tlast;
endmodule

module axis_packet_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]        s_tlast,
    output logic [NUM_SRC-1:0]        s_tready,
    input  logic [NUM_SRC-1:0]        src_enable,
    output logic                      m_tvalid,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tlast,
    output logic [ID_W-1:0]           m_tid,
    input  logic                      m_tready,
    output logic                      busy,
    output logic [CNT_W-1:0]          pkt_count
);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SRC - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] last_grant;

    logic [NUM_SRC-1:0]             lane_valid;
    logic [NUM_SRC-1:0]             lane_last;
    logic [NUM_SRC-1:0][DATA_W-1:0] lane_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_lane
            axis_arb_lane #(.DATA_W(DATA_W), .ID_W(ID_W), .IDX(gi)) u_lane (
                .busy      (busy),
                .grant     (grant),
                .s_tvalid  (s_tvalid[gi]),
                .s_tdata   (s_tdata[gi*DATA_W +: DATA_W]),
                .s_tlast   (s_tlast[gi]),
                .m_tready  (m_tready),
                .s_tready  (s_tready[gi]),
                .sel_valid (lane_valid[gi]),
                .sel_data  (lane_data[gi]),
                .sel_last  (lane_last[gi])
            );
        end
    endgenerate

    // At most one lane is selected, so an OR merge is a mux.
    always_comb begin
        m_tdata = '0;
        for (int i = 0; i < NUM_SRC; i++) m_tdata = m_tdata | lane_data[i];
    end
    assign m_tvalid = |lane_valid;
    assign m_tlast  = |lane_last;
    // grant is only rewritten on a new arbitration, so it doubles as the
    // "last granted id" shown while idle.
    assign m_tid    = grant;

    // Round-robin pick: walk from last_grant+1 upward with wrap at NUM_SRC,
    // first requesting source wins. The just-finished source is checked last.
    logic [NUM_SRC-1:0] req;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_found;

    assign req = s_tvalid & src_enable;

    always_comb begin
        cand       = last_grant;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            grant      <= '0;
            last_grant <= LAST_ID;
            pkt_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Grant lands on this edge; first beat can move next cycle.
                    if (pick_found) begin
                        grant <= pick_idx;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Gaps in s_tvalid keep the grant; only an accepted tlast
                    // beat releases it.
                    if (m_tvalid && m_tready && m_tlast) begin
                        last_grant <= grant;
                        busy       <= 1'b0;
                        pkt_count  <= pkt_count + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;
    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;   // small so the random run exercises wrap

    logic                      clk;
    logic                      resetn;
    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC*DATA_W-1:0] s_tdata;
    logic [NUM_SRC-1:0]        s_tlast;
    logic [NUM_SRC-1:0]        s_tready;
    logic [NUM_SRC-1:0]        src_enable;
    logic                      m_tvalid;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tlast;
    logic [ID_W-1:0]           m_tid;
    logic                      m_tready;
    logic                      busy;
    logic [CNT_W-1:0]          pkt_count;

    axis_packet_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .src_enable(src_enable),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tid(m_tid),
        .m_tready(m_tready), .busy(busy), .pkt_count(pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Owner of the output (-1 when nobody holds a grant), the most recently
    // finished source, the id shown on m_tid, and the packet counter.
    int mo, ml, mtid, mcnt;
    logic [NUM_SRC-1:0] hs;      // per-source handshakes this cycle (from model)
    int dut_done[$];             // m_tid of every tlast beat the DUT accepted

    function automatic int rr_pick(input logic [NUM_SRC-1:0] rq, input int last);
        for (int k = 1; k <= NUM_SRC; k++) begin
            int j;
            j = (last + k) % NUM_SRC;
            if (rq[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [20:0] model_out();
        logic [3:0] sr; logic v; logic [7:0] d; logic l; logic [1:0] id; logic b;
        sr = '0; v = 0; d = '0; l = 0; b = 0; id = 2'(mtid);
        if (mo >= 0) begin
            v  = s_tvalid[mo];
            d  = s_tdata[mo*DATA_W +: DATA_W];
            l  = s_tlast[mo];
            sr = 4'(m_tready) << mo;
            b  = 1'b1;
        end
        return {sr, v, d, l, id, b, 4'(mcnt)};
    endfunction

    task automatic model_update();
        if (!resetn) begin
            mo = -1; ml = NUM_SRC - 1; mtid = 0; mcnt = 0;
        end else if (mo < 0) begin
            int p;
            p = rr_pick(s_tvalid & src_enable, ml);
            if (p >= 0) begin mo = p; mtid = p; end
        end else if (s_tvalid[mo] && m_tready && s_tlast[mo]) begin
            ml = mo; mo = -1; mcnt = (mcnt + 1) % (1 << CNT_W);
        end
    endtask

    // One clock: inputs already driven at the falling edge.
    task automatic step(input bit cmp);
        logic [20:0] exp_o, act_o;
        #1;
        exp_o = model_out();
        act_o = {s_tready, m_tvalid, m_tdata, m_tlast, m_tid, busy, pkt_count};
        hs = s_tvalid & exp_o[20:17];
        if (resetn && m_tvalid && m_tready && m_tlast) dut_done.push_back(int'(m_tid));
        if (cmp) chk("model", 64'(act_o), 64'(exp_o));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(0); step(0);
        resetn = 1'b1;
    endtask

    // ---------------- packet source driver ----------------
    int bc[NUM_SRC];
    int plen;
    logic [NUM_SRC-1:0] drv_v;

    task automatic drive();
        for (int i = 0; i < NUM_SRC; i++) begin
            s_tvalid[i] = drv_v[i];
            s_tdata[i*DATA_W +: DATA_W] = 8'(i*16 + bc[i]);
            s_tlast[i] = (bc[i] == plen - 1);
        end
    endtask

    task automatic advance();
        for (int i = 0; i < NUM_SRC; i++)
            if (hs[i]) bc[i] = (bc[i] == plen - 1) ? 0 : bc[i] + 1;
    endtask

    task automatic clr_bc();
        for (int i = 0; i < NUM_SRC; i++) bc[i] = 0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0] tv; logic [31:0] td; logic [3:0] tl; logic mr;
        logic ev; logic [7:0] ed; logic el; logic [1:0] eid; logic eb;
        logic [3:0] ecnt; logic [3:0] esr;
    } vec_t;
    vec_t vt[17];

    initial begin
        int exp_a[5];
        int exp_b[12];
        bit cleared;

        // tv, td, tl, mr | ev, ed, el, eid, eb, ecnt, esr
        vt[0]  = '{4'h0, 32'h0,         4'h0, 1, 0, 8'h00, 0, 2'd0, 0, 4'd0, 4'h0};
        vt[1]  = '{4'h4, 32'h0010_0000, 4'h0, 1, 0, 8'h00, 0, 2'd0, 0, 4'd0, 4'h0};
        vt[2]  = '{4'h4, 32'h0010_0000, 4'h0, 1, 1, 8'h10, 0, 2'd2, 1, 4'd0, 4'h4};
        vt[3]  = '{4'h4, 32'h0011_0000, 4'h0, 1, 1, 8'h11, 0, 2'd2, 1, 4'd0, 4'h4};
        vt[4]  = '{4'h4, 32'h0012_0000, 4'h4, 1, 1, 8'h12, 1, 2'd2, 1, 4'd0, 4'h4};
        vt[5]  = '{4'h0, 32'h0,         4'h0, 1, 0, 8'h00, 0, 2'd2, 0, 4'd1, 4'h0};
        vt[6]  = '{4'h2, 32'h0000_1D00, 4'h0, 1, 0, 8'h00, 0, 2'd2, 0, 4'd1, 4'h0};
        vt[7]  = '{4'h3, 32'h0000_1DA0, 4'h1, 1, 1, 8'h1D, 0, 2'd1, 1, 4'd1, 4'h2};
        vt[8]  = '{4'h3, 32'h0000_1EA0, 4'h1, 0, 1, 8'h1E, 0, 2'd1, 1, 4'd1, 4'h0};
        vt[9]  = '{4'h3, 32'h0000_1EA0, 4'h1, 1, 1, 8'h1E, 0, 2'd1, 1, 4'd1, 4'h2};
        vt[10] = '{4'h3, 32'h0000_1FA0, 4'h1, 0, 1, 8'h1F, 0, 2'd1, 1, 4'd1, 4'h0};
        vt[11] = '{4'h3, 32'h0000_1FA0, 4'h1, 1, 1, 8'h1F, 0, 2'd1, 1, 4'd1, 4'h2};
        vt[12] = '{4'h3, 32'h0000_20A0, 4'h3, 0, 1, 8'h20, 1, 2'd1, 1, 4'd1, 4'h0};
        vt[13] = '{4'h3, 32'h0000_20A0, 4'h3, 1, 1, 8'h20, 1, 2'd1, 1, 4'd1, 4'h2};
        vt[14] = '{4'h1, 32'h0000_00A0, 4'h1, 1, 0, 8'h00, 0, 2'd1, 0, 4'd2, 4'h0};
        vt[15] = '{4'h1, 32'h0000_00A0, 4'h1, 1, 1, 8'hA0, 1, 2'd0, 1, 4'd2, 4'h1};
        vt[16] = '{4'h0, 32'h0,         4'h0, 1, 0, 8'h00, 0, 2'd0, 0, 4'd3, 4'h0};

        exp_a = '{0, 1, 2, 3, 0};
        exp_b = '{1, 3, 1, 3, 1, 3, 1, 1, 1, 1, 1, 1};

        resetn = 1'b0; s_tvalid = '0; s_tdata = '0; s_tlast = '0;
        src_enable = 4'hF; m_tready = 1'b1;
        mo = -1; ml = NUM_SRC - 1; mtid = 0; mcnt = 0; hs = '0;
        plen = 1; drv_v = '0; clr_bc();
        @(negedge clk);
        do_reset();

        // Idle after reset.
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("idle_after_reset", {60'd0, m_tvalid, busy, s_tready != 0, pkt_count != 0}, 64'd0);
            @(posedge clk); @(negedge clk);
        end

        // Single packet from source 2, then stalled packet from source 1.
        for (int k = 0; k < 17; k++) begin
            s_tvalid = vt[k].tv; s_tdata = vt[k].td; s_tlast = vt[k].tl; m_tready = vt[k].mr;
            #1;
            chk($sformatf("vec%0d", k),
                64'({s_tready, m_tvalid, m_tdata, m_tlast, m_tid, busy, pkt_count}),
                64'({vt[k].esr, vt[k].ev, vt[k].ed, vt[k].el, vt[k].eid, vt[k].eb, vt[k].ecnt}));
            @(posedge clk); @(negedge clk);
        end

        // All sources offering 2-beat packets: strict rotation.
        s_tvalid = '0; m_tready = 1'b1; src_enable = 4'hF;
        do_reset();
        plen = 2; drv_v = 4'hF; clr_bc(); dut_done.delete();
        for (int c = 0; c < 15; c++) begin drive(); step(1); advance(); end
        chk("rr_count", 64'(pkt_count), 64'd5);
        chk("rr_npkts", 64'(dut_done.size()), 64'd5);
        for (int i = 0; i < 5 && i < dut_done.size(); i++)
            chk($sformatf("rr_order%0d", i), 64'(dut_done[i]), 64'(exp_a[i]));

        // Masked sources, then disable source 3 while it owns the output.
        s_tvalid = '0;
        do_reset();
        src_enable = 4'b1010; plen = 2; drv_v = 4'hF; clr_bc(); dut_done.delete();
        cleared = 0;
        for (int c = 0; c < 36; c++) begin
            if (!cleared && mo == 3 && dut_done.size() >= 5) begin
                src_enable = 4'b0010; cleared = 1;
            end
            drive(); step(1); advance();
        end
        chk("mask_npkts", 64'(dut_done.size()), 64'd12);
        for (int i = 0; i < 12 && i < dut_done.size(); i++)
            chk($sformatf("mask_order%0d", i), 64'(dut_done[i]), 64'(exp_b[i]));

        // Reset on beat 2 of a 4-beat packet.
        s_tvalid = '0; src_enable = 4'hF;
        do_reset();
        plen = 4; drv_v = 4'b0001; clr_bc();
        drive(); step(1); advance();
        drive(); step(1); advance();
        resetn = 1'b0; drive(); step(1); advance();
        resetn = 1'b1;
        drv_v = 4'hF; clr_bc(); drive();
        #1;
        chk("rst_mid_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst_mid_tready", 64'(s_tready), 64'd0);
        chk("rst_mid_count", 64'(pkt_count), 64'd0);
        step(1); advance();
        drive();
        #1;
        chk("rst_first_grant", 64'({busy, m_tid}), 64'({1'b1, 2'd0}));
        step(1); advance();

        // Random traffic against the model, with occasional resets.
        s_tvalid = '0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            resetn   = ($urandom_range(0, 299) != 0);
            s_tvalid = 4'($urandom);
            s_tdata  = $urandom;
            for (int i = 0; i < NUM_SRC; i++) s_tlast[i] = ($urandom_range(0, 2) == 0);
            src_enable = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            m_tready = ($urandom_range(0, 3) != 0);
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
